ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 16-bit pipelined CPU. It sits directly downstream of the ID/EX pipeline register and consumes that register's outputs: a 4-bit opcode, 16-bit operands, a 16-bit control word and 4-bit register fields. It drives the EX/MEM register. Single-cycle ALU operations resolve combinationally. MUL and DIV run iteratively over several cycles; during that time the block freezes the front of the pipeline and feeds bubbles downstream.

## Interface
- WIDTH, 16: datapath width (operands, results, control word).
- ITER, 16: iteration count for MUL/DIV; equals WIDTH.
- clk  in  1  clock; all state updates on posedge.
- rest  in  1  reset, synchronous, active-high.
- Controll_Signal_In  in  16  control word from ID/EX.
- OpCode_In  in  4  operation from ID/EX.
- Source1_In  in  16  operand A.
- Source2_In  in  16  operand B (register or immediate, already selected upstream).
- Read1_In  in  16  store data; passed through unchanged.
- Rd_In, Rt_In  in  4 each  register fields; passed through unchanged.
- Result_Out  out  16  ALU / MUL / DIV result.
- Zero_Out  out  1  Result_Out == 0.
- Controll_Signal_Out  out  16  Controll_Signal_In, or 0 (bubble) while Freze_Out=1.
- Read1_Out, Rd_Out, Rt_Out  out  16/4/4  pass-through.
- Freze_Out  out  1  hold request to ID/EX, IF/ID and PC.

## Operation
- Opcodes:
  - 0 NOP: result 0.
  - 1 ADD, 2 SUB: modulo 2^16.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SHL, 7 SHR (logical): shift amount = B[3:0].
  - 8 SLT: signed A<B → 1, else 0.
  - 9 MUL: low 16 bits of unsigned A*B.
  - A DIV: unsigned quotient.
  - B MOD: unsigned remainder.
  - C–F: behave as NOP.
- Single-cycle ops (0–8, C–F): purely combinational from the inputs. Freze_Out=0.
- MUL/DIV/MOD FSM states:
  - IDLE → LOAD happens inside IDLE. If IDLE and the opcode is 9/A/B: latch A and B, clear the counter, go to RUN. Freze_Out=1 this cycle.
  - RUN: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per cycle. The counter runs 0..ITER-1. At ITER-1, go to DONE. Freze_Out=1.
  - DONE: Result_Out = latched result, Freze_Out=0, Controll_Signal_Out = Controll_Signal_In. Next edge: go to IDLE unconditionally.
- Back-to-back MUL: the second MUL enters EX in the cycle after DONE, with the FSM in IDLE, and starts normally. DONE never restarts directly.
- Divide by zero: quotient 0xFFFF, remainder = A. Still takes the full iteration count; no exception.
- While Freze_Out=1:
  - Controll_Signal_Out=0, so EX/MEM captures a bubble.
  - Result_Out is don't-care and is driven 0.
- Operands are sampled only in IDLE. Input changes during RUN are ignored; inputs are held anyway by the freeze.
- Reset: FSM→IDLE, counter, operand and result registers → 0. Reset takes priority over every transition, including mid-RUN. The aborted operation is discarded with no output.
- Reset values (with a NOP on the inputs): Result_Out=0, Zero_Out=1, Freze_Out=0, Controll_Signal_Out=0.

## Timing
- Single-cycle ops: 0-cycle combinational latency. Results are captured by EX/MEM at the next edge.
- MUL/DIV/MOD:
  - Occupies EX for ITER+2 = 18 cycles (IDLE 1, RUN 16, DONE 1).
  - Freze_Out is high for 17 consecutive cycles.
  - EX/MEM receives 17 bubbles, then the result in the DONE cycle.
- Freze_Out is Mealy in IDLE (depends on OpCode_In) and Moore in RUN/DONE. No combinational path from Freze_Out back to the inputs.
- rest asserted at edge N → IDLE from cycle N+1. Freze_Out then follows the current opcode.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OP_NOP..OP_MOD;
  - WIDTH;
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module `muldiv_iter`: owns the FSM, counter, operand/partial registers and both algorithms. Ports: start, op_is_div, op_is_mod, a, b → busy, done, result.
- `ex_stage` holds the combinational ALU, the result mux, bubble insertion and the pass-throughs.

## Test plan
- Reset, then ADD 0x7FFF+0x0001 → Result_Out=0x8000 in the same cycle, Zero_Out=0, Freze_Out=0. SUB 5-5 → 0x0000, Zero_Out=1.
- SLT A=0xFFFF B=0x0001 → 1. SHR A=0x8000 B=0x0013 → 0x1000 (only B[3:0] used).
- MUL 0x0123*0x0045 → Freze_Out high 17 cycles, bubbles downstream, then 0x4E6F in DONE with the control word restored. Check 18-cycle occupancy.
- DIV 1000/7 → 0x008E. MOD 1000/7 → 0x0006. DIV 0x1234/0 → 0xFFFF. MOD 0x1234/0 → 0x1234.
- Back-to-back MUL, MUL, ADD → each MUL takes 18 cycles and the ADD follows immediately. No lost or duplicated results.
- rest asserted at RUN count 7 → next cycle IDLE, Freze_Out=0 with a NOP input, no result emitted. A subsequent MUL completes correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: datapath width, opcodes and
// the iterative MUL/DIV sequencer states.
package cpu_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_SLT = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_MOD = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } md_state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; the master side is the surrounding
// pipeline, the slave side is the execute stage.
interface ex_stage_if #(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH
);
  logic [WIDTH-1:0] Controll_Signal_In;
  logic [3:0]       OpCode_In;
  logic [WIDTH-1:0] Source1_In;
  logic [WIDTH-1:0] Source2_In;
  logic [WIDTH-1:0] Read1_In;
  logic [3:0]       Rd_In;
  logic [3:0]       Rt_In;

  logic [WIDTH-1:0] Result_Out;
  logic             Zero_Out;
  logic [WIDTH-1:0] Controll_Signal_Out;
  logic [WIDTH-1:0] Read1_Out;
  logic [3:0]       Rd_Out;
  logic [3:0]       Rt_Out;
  logic             Freze_Out;

  modport master (
    output Controll_Signal_In, OpCode_In, Source1_In, Source2_In,
           Read1_In, Rd_In, Rt_In,
    input  Result_Out, Zero_Out, Controll_Signal_Out, Read1_Out,
           Rd_Out, Rt_Out, Freze_Out
  );

  modport slave (
    input  Controll_Signal_In, OpCode_In, Source1_In, Source2_In,
           Read1_In, Rd_In, Rt_In,
    output Result_Out, Zero_Out, Controll_Signal_Out, Read1_Out,
           Rd_Out, Rt_Out, Freze_Out
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider: one bit per cycle,
// IDLE (load) -> RUN (ITER steps) -> DONE (result valid for one cycle).
module muldiv_iter
  import cpu_pkg::*;
#(
  parameter int unsigned W    = WIDTH,
  parameter int unsigned ITER = W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_is_div,
  input  logic         op_is_mod,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  x_q, x_d;       // multiplicand (MUL) / dividend->quotient (DIV)
  logic [W-1:0]  y_q, y_d;       // multiplier (MUL) / divisor (DIV)
  logic [W-1:0]  p_q, p_d;       // product (MUL) / partial remainder (DIV)
  logic          div_mode_q, div_mode_d;
  logic          sel_rem_q, sel_rem_d;
  logic [W-1:0]  result_q, result_d;

  logic [W:0]    shifted, diff;
  logic          ge;
  logic [W-1:0]  x_step, y_step, p_step;

  // One algorithm step from the current registers; mode picks which applies.
  always_comb begin
    shifted = {p_q, x_q[W-1]};
    diff    = shifted - {1'b0, y_q};
    ge      = (shifted >= {1'b0, y_q});
    if (div_mode_q) begin
      p_step = ge ? diff[W-1:0] : shifted[W-1:0];
      x_step = {x_q[W-2:0], ge};
      y_step = y_q;
    end else begin
      p_step = y_q[0] ? (p_q + x_q) : p_q;
      x_step = x_q << 1;
      y_step = y_q >> 1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    p_d        = p_q;
    div_mode_d = div_mode_q;
    sel_rem_d  = sel_rem_q;
    result_d   = result_q;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy       = 1'b1;
          x_d        = a;
          y_d        = b;
          p_d        = '0;
          cnt_d      = '0;
          div_mode_d = op_is_div | op_is_mod;
          sel_rem_d  = op_is_mod;
          state_d    = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        x_d   = x_step;
        y_d   = y_step;
        p_d   = p_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = (div_mode_q && !sel_rem_q) ? x_step : p_step;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      p_q        <= '0;
      div_mode_q <= 1'b0;
      sel_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      p_q        <= p_d;
      div_mode_q <= div_mode_d;
      sel_rem_q  <= sel_rem_d;
      result_q   <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, iterative MUL/DIV/MOD with pipeline
// freeze, bubble insertion towards EX/MEM and register-field pass-through.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned ITER = WIDTH
) (
  input logic       clk,
  input logic       rest,
  ex_stage_if.slave bus
);

  logic [WIDTH-1:0] src_a, src_b;
  logic [WIDTH-1:0] alu_res, md_result, result;
  logic             md_start, md_is_div, md_is_mod;
  logic             md_busy, md_done;

  assign src_a = bus.Source1_In;
  assign src_b = bus.Source2_In;

  always_comb begin
    alu_res = '0;
    case (bus.OpCode_In)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SHL:  alu_res = src_a << src_b[3:0];
      OP_SHR:  alu_res = src_a >> src_b[3:0];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_res = '0;
    endcase
  end

  assign md_start  = is_multicycle(bus.OpCode_In);
  assign md_is_div = (bus.OpCode_In == OP_DIV);
  assign md_is_mod = (bus.OpCode_In == OP_MOD);

  muldiv_iter #(
    .W    (WIDTH),
    .ITER (ITER)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rest),
    .start     (md_start),
    .op_is_div (md_is_div),
    .op_is_mod (md_is_mod),
    .a         (src_a),
    .b         (src_b),
    .busy      (md_busy),
    .done      (md_done),
    .result    (md_result)
  );

  // DONE wins over the ALU: the held MUL/DIV opcode would otherwise decode as 0.
  always_comb begin
    if (md_done)      result = md_result;
    else if (md_busy) result = '0;
    else              result = alu_res;
  end

  assign bus.Result_Out          = result;
  assign bus.Zero_Out            = (result == '0);
  assign bus.Freze_Out           = md_busy;
  assign bus.Controll_Signal_Out = md_busy ? '0 : bus.Controll_Signal_In;
  assign bus.Read1_Out           = bus.Read1_In;
  assign bus.Rd_Out              = bus.Rd_In;
  assign bus.Rt_Out              = bus.Rt_In;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage: a per-instruction reference
// model produces one expected output set per cycle, checked at the falling edge.
module tb_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rest = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if #(.WIDTH(WIDTH)) bus ();

  ex_stage #(.ITER(WIDTH)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] result;
    logic        zero;
    logic        freeze;
    logic [15:0] ctrl;
    logic [15:0] read1;
    logic [3:0]  rd;
    logic [3:0]  rt;
    logic [3:0]  op;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   instr_no = 0;

  function automatic logic [15:0] ref_result(input logic [3:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] prod;
    int unsigned sh;
    sh = b % 16;
    case (op)
      4'h1: return 16'((a + b) % 65536);
      4'h2: return 16'((32'(a) + 32'h10000 - 32'(b)) % 65536);
      4'h3: return a & b;
      4'h4: return a | b;
      4'h5: return a ^ b;
      4'h6: return 16'((32'(a) * (32'd1 << sh)) % 65536);
      4'h7: return 16'(32'(a) / (32'd1 << sh));
      4'h8: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'h9: begin
        prod = 32'(a) * 32'(b);
        return prod[15:0];
      end
      4'hA: return (b == 16'd0) ? 16'hFFFF : a / b;
      4'hB: return (b == 16'd0) ? a : a % b;
      default: return 16'd0;
    endcase
  endfunction

  task automatic pin(input string name, input logic [3:0] op,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] want);
    logic [15:0] got;
    got = ref_result(op, a, b);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL model_%s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive_cycle(input logic r, input logic [3:0] op,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] ctrl, input logic [15:0] r1,
                             input logic [3:0] rd, input logic [3:0] rt,
                             input exp_t e);
    @(posedge clk);
    #1;
    rest                   = r;
    bus.OpCode_In          = op;
    bus.Source1_In         = a;
    bus.Source2_In         = b;
    bus.Controll_Signal_In = ctrl;
    bus.Read1_In           = r1;
    bus.Rd_In              = rd;
    bus.Rt_In              = rt;
    exp_q.push_back(e);
  endtask

  // Instruction stays on the inputs for its whole occupancy of EX (1 or 18 cycles).
  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] ctrl,
                       input int unsigned abort_at);
    exp_t        e;
    logic [15:0] r1, res;
    logic [3:0]  rd, rt;
    int unsigned n;
    r1  = 16'($urandom);
    rd  = 4'($urandom);
    rt  = 4'($urandom);
    res = ref_result(op, a, b);
    n   = (op == 4'h9 || op == 4'hA || op == 4'hB) ? WIDTH + 2 : 1;
    instr_no++;
    for (int unsigned k = 0; k < n; k++) begin
      e.read1 = r1;
      e.rd    = rd;
      e.rt    = rt;
      e.op    = op;
      e.idx   = instr_no;
      if (k == n - 1) begin
        e.result = res;
        e.zero   = (res == 16'd0);
        e.freeze = 1'b0;
        e.ctrl   = ctrl;
      end else begin
        e.result = 16'd0;
        e.zero   = 1'b1;
        e.freeze = 1'b1;
        e.ctrl   = 16'd0;
      end
      if (abort_at != 0 && k == abort_at) begin
        drive_cycle(1'b1, op, a, b, ctrl, r1, rd, rt, e);
        break;
      end
      drive_cycle(1'b0, op, a, b, ctrl, r1, rd, rt, e);
    end
  endtask

  task automatic idle_cycle(input logic r);
    exp_t e;
    e.result = 16'd0;
    e.zero   = 1'b1;
    e.freeze = 1'b0;
    e.ctrl   = 16'd0;
    e.read1  = 16'h0;
    e.rd     = 4'h0;
    e.rt     = 4'h0;
    e.op     = 4'h0;
    e.idx    = -1;
    drive_cycle(r, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.Result_Out !== e.result || bus.Zero_Out !== e.zero ||
          bus.Freze_Out !== e.freeze || bus.Controll_Signal_Out !== e.ctrl ||
          bus.Read1_Out !== e.read1 || bus.Rd_Out !== e.rd || bus.Rt_Out !== e.rt) begin
        failures++;
        $display("FAIL ex_cycle t=%0t instr=%0d op=%h got res=%h z=%b frz=%b ctl=%h r1=%h rd=%h rt=%h want res=%h z=%b frz=%b ctl=%h r1=%h rd=%h rt=%h",
                 $time, e.idx, e.op, bus.Result_Out, bus.Zero_Out, bus.Freze_Out,
                 bus.Controll_Signal_Out, bus.Read1_Out, bus.Rd_Out, bus.Rt_Out,
                 e.result, e.zero, e.freeze, e.ctrl, e.read1, e.rd, e.rt);
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;

    rest                   = 1'b1;
    bus.OpCode_In          = 4'h0;
    bus.Source1_In         = '0;
    bus.Source2_In         = '0;
    bus.Controll_Signal_In = '0;
    bus.Read1_In           = '0;
    bus.Rd_In              = '0;
    bus.Rt_In              = '0;

    pin("add", 4'h1, 16'h7FFF, 16'h0001, 16'h8000);
    pin("sub", 4'h2, 16'h0005, 16'h0005, 16'h0000);
    pin("slt", 4'h8, 16'hFFFF, 16'h0001, 16'h0001);
    pin("shr", 4'h7, 16'h8000, 16'h0013, 16'h1000);
    pin("mul", 4'h9, 16'h0123, 16'h0045, 16'h4E6F);
    pin("div", 4'hA, 16'd1000, 16'd7,    16'h008E);
    pin("mod", 4'hB, 16'd1000, 16'd7,    16'h0006);
    pin("div0", 4'hA, 16'h1234, 16'h0000, 16'hFFFF);
    pin("mod0", 4'hB, 16'h1234, 16'h0000, 16'h1234);

    idle_cycle(1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    issue(4'h1, 16'h7FFF, 16'h0001, 16'hA5A5, 0);
    issue(4'h2, 16'h0005, 16'h0005, 16'h1111, 0);
    issue(4'h8, 16'hFFFF, 16'h0001, 16'h2222, 0);
    issue(4'h7, 16'h8000, 16'h0013, 16'h3333, 0);
    issue(4'h9, 16'h0123, 16'h0045, 16'hBEEF, 0);
    issue(4'hA, 16'd1000, 16'd7,    16'h4444, 0);
    issue(4'hB, 16'd1000, 16'd7,    16'h5555, 0);
    issue(4'hA, 16'h1234, 16'h0000, 16'h6666, 0);
    issue(4'hB, 16'h1234, 16'h0000, 16'h7777, 0);
    issue(4'h9, 16'hFFFF, 16'hFFFF, 16'h8888, 0);
    issue(4'h9, 16'h1234, 16'h5678, 16'h9999, 0);
    issue(4'h1, 16'h0102, 16'h0304, 16'hAAAA, 0);

    // Reset lands while the sequencer is at RUN count 7 (9th cycle of the MUL).
    issue(4'h9, 16'h0123, 16'h0045, 16'hCCCC, 8);
    idle_cycle(1'b0);
    issue(4'h9, 16'h00FF, 16'h0101, 16'hDDDD, 0);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
      issue(op, a, b, 16'($urandom), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
